// File: rtl/vga_timing_gen.sv
// VGA timing generator with built-in test patterns.
// Free-running horizontal/vertical counters advance on the pixel enable.
// Every output is registered from the pre-increment counter values, so the
// outputs describe the pixel the counters pointed at one pix_en period earlier.
module vga_timing_gen #(
    parameter int H_VISIBLE = 800,
    parameter int H_FRONT   = 40,
    parameter int H_SYNC    = 128,
    parameter int H_BACK    = 88,
    parameter int V_VISIBLE = 600,
    parameter int V_FRONT   = 1,
    parameter int V_SYNC    = 4,
    parameter int V_BACK    = 23,
    parameter int H_POL     = 1,
    parameter int V_POL     = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pix_en,
    input  logic [1:0]  pattern_sel,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [10:0] x,
    output logic [9:0]  y,
    output logic        frame_start,
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    // Thresholds are one bit wider than the counters so a sync pulse ending
    // exactly at the largest supported total still compares correctly.
    localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [11:0] H_VIS_END  = 12'(H_VISIBLE);
    localparam logic [11:0] H_SYNC_BEG = 12'(H_VISIBLE + H_FRONT);
    localparam logic [11:0] H_SYNC_END = 12'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] V_VIS_END  = 11'(V_VISIBLE);
    localparam logic [10:0] V_SYNC_BEG = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] V_SYNC_END = 11'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic        H_ACT      = 1'(H_POL);
    localparam logic        V_ACT      = 1'(V_POL);

    logic [10:0] hc;
    logic [9:0]  vc;
    logic [3:0]  frame_cnt;
    logic [1:0]  pattern_reg;

    logic        h_wrap;
    logic        v_wrap;
    logic        at_origin;
    logic        visible;
    logic        h_active;
    logic        v_active;
    logic [1:0]  pattern_now;
    logic [3:0]  frame_now;
    logic [2:0]  bar_idx;
    logic [3:0]  red_next;
    logic [3:0]  green_next;
    logic [3:0]  blue_next;

    // Decode the current counter position into timing regions.
    always_comb begin
        h_wrap    = (hc == H_LAST);
        v_wrap    = (vc == V_LAST);
        at_origin = (hc == 11'd0) && (vc == 10'd0);
        visible   = ({1'b0, hc} < H_VIS_END) && ({1'b0, vc} < V_VIS_END);
        h_active  = ({1'b0, hc} >= H_SYNC_BEG) && ({1'b0, hc} < H_SYNC_END);
        v_active  = ({1'b0, vc} >= V_SYNC_BEG) && ({1'b0, vc} < V_SYNC_END);
        // The origin pixel already belongs to the new frame, so it sees the
        // freshly sampled pattern and the incremented frame count.
        pattern_now = at_origin ? pattern_sel : pattern_reg;
        frame_now   = at_origin ? frame_cnt + 4'd1 : frame_cnt;
        bar_idx     = 3'((32'(hc) << 3) / 32'(H_VISIBLE));
    end

    // Test pattern colour for the current position; black during blanking.
    always_comb begin
        red_next   = 4'h0;
        green_next = 4'h0;
        blue_next  = 4'h0;
        if (visible) begin
            case (pattern_now)
                2'd0: begin
                    red_next   = 4'h7;
                    green_next = 4'h1;
                    blue_next  = 4'hE;
                end
                2'd1: begin
                    red_next   = bar_idx[2] ? 4'hF : 4'h0;
                    green_next = bar_idx[1] ? 4'hF : 4'h0;
                    blue_next  = bar_idx[0] ? 4'hF : 4'h0;
                end
                2'd2: begin
                    red_next   = (hc[5] ^ vc[5]) ? 4'hF : 4'h0;
                    green_next = (hc[5] ^ vc[5]) ? 4'hF : 4'h0;
                    blue_next  = (hc[5] ^ vc[5]) ? 4'hF : 4'h0;
                end
                default: begin
                    red_next   = hc[7:4];
                    green_next = vc[7:4];
                    blue_next  = frame_now;
                end
            endcase
        end
    end

    // Horizontal and vertical position counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hc <= 11'd0;
            vc <= 10'd0;
        end else if (pix_en) begin
            hc <= h_wrap ? 11'd0 : hc + 11'd1;
            if (h_wrap) begin
                vc <= v_wrap ? 10'd0 : vc + 10'd1;
            end
        end
    end

    // Per-frame state: pattern selection and frame counter update at frame start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt   <= 4'd0;
            pattern_reg <= 2'd0;
        end else if (pix_en && at_origin) begin
            frame_cnt   <= frame_cnt + 4'd1;
            pattern_reg <= pattern_sel;
        end
    end

    // Registered video outputs; frame_start is a single-clock strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync       <= ~H_ACT;
            vsync       <= ~V_ACT;
            de          <= 1'b0;
            x           <= 11'd0;
            y           <= 10'd0;
            frame_start <= 1'b0;
            red         <= 4'h0;
            green       <= 4'h0;
            blue        <= 4'h0;
        end else begin
            frame_start <= pix_en && at_origin;
            if (pix_en) begin
                hsync <= h_active ? H_ACT : ~H_ACT;
                vsync <= v_active ? V_ACT : ~V_ACT;
                de    <= visible;
                x     <= visible ? hc : 11'd0;
                y     <= visible ? vc : 10'd0;
                red   <= red_next;
                green <= green_next;
                blue  <= blue_next;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen: a reduced-size instance checked pixel by
// pixel against a scoreboard model and a table of hand-computed pixels, plus
// a default-parameter instance checked for line-level sync timing.
module tb_vga_timing_gen;

    localparam int HV = 128, HF = 8, HS = 16, HB = 8, HT = HV + HF + HS + HB;
    localparam int VV = 48, VF = 2, VS = 3, VB = 3, VT = VV + VF + VS + VB;
    localparam int NSPOT = 17;

    typedef struct packed {
        logic        hsync;
        logic        vsync;
        logic        de;
        logic [10:0] x;
        logic [9:0]  y;
        logic        fs;
        logic [3:0]  r;
        logic [3:0]  g;
        logic [3:0]  b;
    } outs_t;

    typedef struct {
        outs_t o;
        int    hc;
        int    vc;
        int    frame;
        bit    upd;
    } exp_t;

    typedef struct {
        int         frame;
        int         hc;
        int         vc;
        logic       de;
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } vec_t;

    // hsync inactive level is 1 (H_POL=0), vsync inactive is 0 (V_POL=1)
    localparam outs_t M_RST = {1'b1, 1'b0, 1'b0, 11'd0, 10'd0, 1'b0, 12'd0};

    logic clk = 1'b0;
    logic rst_n;
    logic m_pix_en, d_pix_en;
    logic [1:0] m_sel, d_sel;
    logic m_hsync, m_vsync, m_de, m_fs;
    logic [10:0] m_x;
    logic [9:0] m_y;
    logic [3:0] m_red, m_green, m_blue;
    logic d_hsync, d_vsync, d_de, d_fs;
    logic [10:0] d_x;
    logic [9:0] d_y;
    logic [3:0] d_red, d_green, d_blue;
    outs_t m_o;

    assign m_o = {m_hsync, m_vsync, m_de, m_x, m_y, m_fs, m_red, m_green, m_blue};

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .H_POL(0), .V_POL(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pix_en(m_pix_en), .pattern_sel(m_sel),
        .hsync(m_hsync), .vsync(m_vsync), .de(m_de), .x(m_x), .y(m_y),
        .frame_start(m_fs), .red(m_red), .green(m_green), .blue(m_blue)
    );

    vga_timing_gen dut_def (
        .clk(clk), .rst_n(rst_n), .pix_en(d_pix_en), .pattern_sel(d_sel),
        .hsync(d_hsync), .vsync(d_vsync), .de(d_de), .x(d_x), .y(d_y),
        .frame_start(d_fs), .red(d_red), .green(d_green), .blue(d_blue)
    );

    int total = 0;
    int bad = 0;
    int spot_hits = 0;
    exp_t sb[$];
    vec_t tbl[NSPOT];

    int mhc, mvc, mframe;
    logic [3:0] mfc;
    logic [1:0] mpat;
    logic [1:0] sel;
    outs_t last;

    // Compare one value against its required value and count the result.
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Behavioural model of one output pixel.
    function automatic outs_t modelOut(int hc, int vc, logic [1:0] pat, logic [3:0] fc, bit fs);
        outs_t o;
        int bar;
        bit vis;
        bit chk;
        vis = (hc < HV) && (vc < VV);
        o.hsync = (hc >= HV + HF && hc < HV + HF + HS) ? 1'b0 : 1'b1;
        o.vsync = (vc >= VV + VF && vc < VV + VF + VS) ? 1'b1 : 1'b0;
        o.de = vis;
        o.x = vis ? 11'(hc) : 11'd0;
        o.y = vis ? 10'(vc) : 10'd0;
        o.fs = fs;
        o.r = 4'h0;
        o.g = 4'h0;
        o.b = 4'h0;
        if (vis) begin
            case (pat)
                2'd0: begin o.r = 4'h7; o.g = 4'h1; o.b = 4'hE; end
                2'd1: begin
                    bar = hc * 8 / HV;
                    o.r = ((bar & 4) != 0) ? 4'hF : 4'h0;
                    o.g = ((bar & 2) != 0) ? 4'hF : 4'h0;
                    o.b = ((bar & 1) != 0) ? 4'hF : 4'h0;
                end
                2'd2: begin
                    chk = (((hc / 32) + (vc / 32)) % 2) == 1;
                    o.r = chk ? 4'hF : 4'h0;
                    o.g = chk ? 4'hF : 4'h0;
                    o.b = chk ? 4'hF : 4'h0;
                end
                default: begin
                    o.r = 4'((hc / 16) % 16);
                    o.g = 4'((vc / 16) % 16);
                    o.b = fc;
                end
            endcase
        end
        return o;
    endfunction

    // Drive one clock of stimulus, push its expectation, then pop and compare.
    task automatic applyStimulus(input bit pe);
        exp_t e;
        exp_t got;
        bit fs;
        fs = 1'b0;
        m_pix_en = pe;
        m_sel = sel;
        if (pe) begin
            if (mhc == 0 && mvc == 0) begin
                mpat = sel;
                mfc = mfc + 4'd1;
                mframe++;
                fs = 1'b1;
            end
            e.o = modelOut(mhc, mvc, mpat, mfc, fs);
            e.hc = mhc;
            e.vc = mvc;
            e.frame = mframe;
            e.upd = 1'b1;
            mhc++;
            if (mhc == HT) begin
                mhc = 0;
                mvc++;
                if (mvc == VT) mvc = 0;
            end
        end else begin
            e.o = last;
            e.o.fs = 1'b0;
            e.hc = -1;
            e.vc = -1;
            e.frame = mframe;
            e.upd = 1'b0;
        end
        last = e.o;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        m_pix_en = 1'b0;
        got = sb.pop_front();
        checkOutput($sformatf("sb f%0d hc%0d vc%0d", got.frame, got.hc, got.vc),
                    64'(m_o), 64'(got.o));
        if (got.upd) begin
            for (int i = 0; i < NSPOT; i++) begin
                if (tbl[i].frame == got.frame && tbl[i].hc == got.hc && tbl[i].vc == got.vc) begin
                    spot_hits++;
                    checkOutput($sformatf("spot%0d", i), {m_de, m_red, m_green, m_blue},
                                {tbl[i].de, tbl[i].r, tbl[i].g, tbl[i].b});
                end
            end
        end
    endtask

    // One random cycle; pattern_sel is scrambled early in each frame and set
    // to the next frame's pattern later, so only frame-start sampling works.
    task automatic runCycle();
        int nxt;
        if (mframe >= 0 && mvc >= 1 && mvc <= 20) begin
            sel = 2'($urandom_range(0, 3));
        end else if (mframe >= 0 && mvc >= 24) begin
            nxt = (mframe + 1 > 3) ? 3 : mframe + 1;
            sel = 2'(nxt);
        end
        applyStimulus($urandom_range(0, 3) != 0);
    endtask

    task automatic resetModel();
        mhc = 0;
        mvc = 0;
        mframe = -1;
        mfc = 4'd0;
        mpat = 2'd0;
        sel = 2'd0;
        last = M_RST;
    endtask

    initial begin
        int first_rise, second_rise, hs_cnt, vs_cnt, fs_cnt, budget;
        logic prev_hs;

        tbl[0]  = '{0, 10, 30, 1'b1, 4'h7, 4'h1, 4'hE};
        tbl[1]  = '{0, 130, 5, 1'b0, 4'h0, 4'h0, 4'h0};
        tbl[2]  = '{0, 20, 50, 1'b0, 4'h0, 4'h0, 4'h0};
        tbl[3]  = '{1, 0, 3, 1'b1, 4'h0, 4'h0, 4'h0};
        tbl[4]  = '{1, 16, 3, 1'b1, 4'h0, 4'h0, 4'hF};
        tbl[5]  = '{1, 40, 3, 1'b1, 4'h0, 4'hF, 4'h0};
        tbl[6]  = '{1, 64, 3, 1'b1, 4'hF, 4'h0, 4'h0};
        tbl[7]  = '{1, 100, 3, 1'b1, 4'hF, 4'hF, 4'h0};
        tbl[8]  = '{1, 127, 3, 1'b1, 4'hF, 4'hF, 4'hF};
        tbl[9]  = '{2, 32, 0, 1'b1, 4'hF, 4'hF, 4'hF};
        tbl[10] = '{2, 32, 32, 1'b1, 4'h0, 4'h0, 4'h0};
        tbl[11] = '{2, 0, 0, 1'b1, 4'h0, 4'h0, 4'h0};
        tbl[12] = '{2, 0, 32, 1'b1, 4'hF, 4'hF, 4'hF};
        tbl[13] = '{2, 128, 0, 1'b0, 4'h0, 4'h0, 4'h0};
        tbl[14] = '{3, 100, 40, 1'b1, 4'h6, 4'h2, 4'h4};
        tbl[15] = '{3, 127, 47, 1'b1, 4'h7, 4'h2, 4'h4};
        tbl[16] = '{3, 15, 15, 1'b1, 4'h0, 4'h0, 4'h4};

        rst_n = 1'b0;
        m_pix_en = 1'b0;
        d_pix_en = 1'b0;
        m_sel = 2'd0;
        d_sel = 2'd0;
        resetModel();
        repeat (2) @(negedge clk);
        checkOutput("reset main", 64'(m_o), 64'(M_RST));
        checkOutput("reset def", {d_hsync, d_vsync, d_de, d_x, d_y, d_fs, d_red, d_green, d_blue}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Default-parameter line timing with pix_en every 6th clock.
        first_rise = -1;
        second_rise = -1;
        hs_cnt = 0;
        vs_cnt = 0;
        fs_cnt = 0;
        prev_hs = 1'b0;
        for (int n = 0; n < 1900; n++) begin
            d_pix_en = 1'b1;
            @(posedge clk);
            @(negedge clk);
            d_pix_en = 1'b0;
            if (d_hsync && !prev_hs) begin
                if (first_rise < 0) first_rise = n;
                else if (second_rise < 0) second_rise = n;
            end
            prev_hs = d_hsync;
            if (n < 1056 && d_hsync) hs_cnt++;
            if (d_vsync) vs_cnt++;
            if (d_fs) fs_cnt++;
            if (n == 0) begin
                checkOutput("def first de", 64'(d_de), 64'd1);
                checkOutput("def first fs", 64'(d_fs), 64'd1);
            end
            if (n == 799) checkOutput("def x799", {d_de, d_x}, {1'b1, 11'd799});
            if (n == 800) checkOutput("def hc800 blank", {d_de, d_x, d_red, d_green, d_blue}, 64'd0);
            @(negedge clk);
            if (n == 0) checkOutput("def fs hold", 64'(d_fs), 64'd0);
            repeat (4) @(negedge clk);
        end
        checkOutput("def hsync start", 64'(first_rise), 64'd840);
        checkOutput("def hsync width", 64'(hs_cnt), 64'd128);
        checkOutput("def line period", 64'(second_rise - first_rise), 64'd1056);
        checkOutput("def vsync idle", 64'(vs_cnt), 64'd0);
        checkOutput("def fs count", 64'(fs_cnt), 64'd1);

        // Four full reduced frames through the scoreboard.
        budget = 60000;
        while (mframe < 4 && budget > 0 && bad < 50) begin
            runCycle();
            budget--;
        end
        checkOutput("frames reached", 64'(mframe), 64'd4);
        checkOutput("spot hits", 64'(spot_hits), 64'(NSPOT));

        // Move into frame 4 to hc=100, vc=20, then abort it with a reset.
        budget = 10000;
        while (!(mhc == 100 && mvc == 20) && budget > 0 && bad < 50) begin
            runCycle();
            budget--;
        end
        checkOutput("midframe reached", {32'(mhc), 32'(mvc)}, {32'd100, 32'd20});

        m_pix_en = 1'b0;
        sel = 2'd0;
        m_sel = 2'd0;
        rst_n = 1'b0;
        #1;
        checkOutput("async reset", 64'(m_o), 64'(M_RST));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput($sformatf("reset hold%0d", i), 64'(m_o), 64'(M_RST));
        end
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("after release", 64'(m_o), 64'(M_RST));
        resetModel();
        applyStimulus(1'b1);
        checkOutput("post-reset pixel", {m_fs, m_de, m_x, m_y, m_red, m_green, m_blue},
                    {1'b1, 1'b1, 11'd0, 10'd0, 4'h7, 4'h1, 4'hE});
        for (int i = 0; i < 400 && bad < 50; i++) runCycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- H_VISIBLE, 800, visible columns
- H_FRONT, 40, horizontal front porch, pixels
- H_SYNC, 128, hsync pulse width, pixels
- H_BACK, 88, horizontal back porch, pixels
- V_VISIBLE, 600, visible lines
- V_FRONT, 1, vertical front porch, lines
- V_SYNC, 4, vsync pulse width, lines
- V_BACK, 23, vertical back porch, lines
- H_POL, 1, hsync active level
- V_POL, 1, vsync active level
REQ-002 Derived constants: H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (default 1056); V_TOTAL = V_VISIBLE+V_FRONT+V_SYNC+V_BACK (default 628).
REQ-003 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, system clock, posedge
- rst_n, in, 1, asynchronous active-low reset
- pix_en, in, 1, pixel-rate enable, one clk wide
- pattern_sel, in, 2, test pattern select
- hsync, out, 1, horizontal sync
- vsync, out, 1, vertical sync
- de, out, 1, display enable (visible pixel)
- x, out, 11, visible column of current output pixel
- y, out, 10, visible line of current output pixel
- frame_start, out, 1, start-of-frame strobe
- red, out, 4, red level
- green, out, 4, green level
- blue, out, 4, blue level
REQ-004 Single clock domain: clk only; rst_n asynchronous, active-low; all outputs registered.

Function
REQ-005 Internal counters: hc 0..H_TOTAL-1, vc 0..V_TOTAL-1; both advance only on clk edges with pix_en=1.
REQ-006 hc wraps H_TOTAL-1 -> 0; vc increments only on the hc wrap; vc wraps V_TOTAL-1 -> 0 when hc also wraps.
REQ-007 Line/frame order: visible, front porch, sync, back porch; hsync active iff H_VISIBLE+H_FRONT <= hc < H_VISIBLE+H_FRONT+H_SYNC; vsync active iff the same rule holds on vc with the V_* values.
REQ-008 Active level is H_POL / V_POL; inactive level is the complement.
REQ-009 Latency: on a pix_en edge, all outputs take values computed from the pre-increment (hc,vc); outputs therefore lag the counters by exactly one pix_en period.
REQ-010 Hold: with pix_en=0, all outputs and counters hold, except frame_start, which SHALL be 0.
REQ-011 de=1 iff hc<H_VISIBLE and vc<V_VISIBLE; x and y equal hc and vc when de=1, and are 0 when de=0.
REQ-012 frame_start=1 for exactly one clk: the cycle in which outputs update to (hc=0, vc=0).
REQ-013 pattern_sel is sampled into an internal register only on the frame_start update; a mid-frame change takes effect at the next frame.
REQ-014 Pattern 0 (solid): r=7, g=1, b=E.
REQ-015 Pattern 1 (colour bars): 8 bars, bar index = x*8/H_VISIBLE with integer division; bar index bits {2,1,0} select r,g,b = F or 0 each.
REQ-016 Pattern 2 (checkerboard): x[5]^y[5] = 1 -> white (F,F,F), else black.
REQ-017 Pattern 3 (gradient): r=x[7:4], g=y[7:4], b=frame counter[3:0].
REQ-018 Frame counter: 4 bits, increments at each frame_start, wraps F -> 0.
REQ-019 Blanking: red, green and blue SHALL be 0 whenever de=0, for every pattern.
REQ-020 Arithmetic: counter widths fixed at 11 bits (horizontal) and 10 bits (vertical); parameter sets with H_TOTAL > 2048 or V_TOTAL > 1024 are unsupported.

Reset
REQ-021 rst_n=0 immediately sets: hc=0, vc=0, frame counter=0, pattern register=0, de=0, x=0, y=0, rgb=0, frame_start=0, hsync=~H_POL, vsync=~V_POL.
REQ-022 Reset mid-frame aborts the frame.
REQ-023 After rst_n rises, the first pix_en edge outputs pixel (0,0) with de=1 and frame_start=1.

Verification
REQ-024 Defaults, pix_en every 6th clk -> hsync high for exactly 128 pix_en periods starting at output hc=840; line period = 1056 pix_en periods.
REQ-025 Defaults -> vsync high on lines 601..604 only; frame period = 628 lines; frame_start once per 663168 pix_en periods.
REQ-026 pattern_sel 0 -> 1 at line 300 -> pattern 0 through end of frame; next frame: x=0 -> (0,0,0), x=100 -> (0,0,F), x=799 -> (F,F,F).
REQ-027 Pattern 2 -> x=32, y=0 gives (F,F,F); x=32, y=32 gives (0,0,0); pixel at hc=800 gives (0,0,0) with de=0.
REQ-028 H_POL=0, V_POL=0, H_VISIBLE=640, H_FRONT=16, H_SYNC=96, H_BACK=48 -> hsync low for hc 656..751; line period 800.
REQ-029 rst_n pulsed low at hc=500, vc=200; pix_en stalled for 3 clks -> reset values of REQ-021 held; first pix_en after release outputs (0,0) with frame_start=1.
